// File: rtl/irq_inject_sched.sv
// Randomised interrupt injector: once the commit PC reaches START_PC, three independent
// channels raise ext/sft/tmr requests after LFSR-derived delays and wait for a handler ack.
module irq_inject_sched #(
  parameter int unsigned       PC_W       = 32,
  parameter logic [PC_W-1:0]   START_PC   = PC_W'(32'h8000015C),
  parameter logic [PC_W-1:0]   EXT_ACK_PC = PC_W'(32'h800000A6),
  parameter logic [PC_W-1:0]   SFT_ACK_PC = PC_W'(32'h800000BE),
  parameter logic [PC_W-1:0]   TMR_ACK_PC = PC_W'(32'h800000D6),
  parameter logic [PC_W-1:0]   TOHOST_PC  = PC_W'(32'h80000086),
  parameter int unsigned       STOP_CNT   = 32,
  parameter int unsigned       DLY_W      = 10,
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  output logic            ext_irq,
  output logic            sft_irq,
  output logic            tmr_irq,
  output logic            armed,
  output logic            done,
  output logic [31:0]     tohost_cnt,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     first_tohost_cycle
);

  typedef enum logic [1:0] {ChIdle, ChWait, ChAssert, ChDone} ch_state_e;

  localparam logic [15:0]    LfsrMask = 16'hB400;
  localparam logic [DLY_W:0] DlyOne   = (DLY_W + 1)'(1);

  logic            hit_start, hit_tohost;
  logic [2:0]      ack_hit;
  logic            stop;
  logic [15:0]     lfsr_q;
  logic [31:0]     cycle_cnt_q, tohost_cnt_q, first_q;
  logic            first_seen_q, armed_q;
  logic [2:0]      irq_q;
  ch_state_e       ch_state_q [3];
  logic [DLY_W:0]  ch_cnt_q   [3];
  logic [DLY_W:0]  dly_load   [3];

  assign hit_start  = cmt_valid && (cmt_pc == START_PC);
  assign hit_tohost = cmt_valid && (cmt_pc == TOHOST_PC);
  assign ack_hit    = {cmt_valid && (cmt_pc == TMR_ACK_PC),
                       cmt_valid && (cmt_pc == SFT_ACK_PC),
                       cmt_valid && (cmt_pc == EXT_ACK_PC)};

  assign stop = tohost_cnt_q > 32'(STOP_CNT);

  // Each channel draws its delay from a different, overlapping LFSR window.
  assign dly_load[0] = {1'b0, lfsr_q[DLY_W-1:0]} + DlyOne;
  assign dly_load[1] = {1'b0, lfsr_q[DLY_W+2:3]} + DlyOne;
  assign dly_load[2] = {1'b0, lfsr_q[DLY_W+5:6]} + DlyOne;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q       <= LFSR_SEED;
      cycle_cnt_q  <= '0;
      tohost_cnt_q <= '0;
      first_q      <= '0;
      first_seen_q <= 1'b0;
      armed_q      <= 1'b0;
      irq_q        <= '0;
      for (int i = 0; i < 3; i++) begin
        ch_state_q[i] <= ChIdle;
        ch_cnt_q[i]   <= '0;
      end
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      lfsr_q      <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);
      if (hit_tohost && (tohost_cnt_q != '1)) begin
        tohost_cnt_q <= tohost_cnt_q + 32'd1;
      end
      if (hit_tohost && !first_seen_q) begin
        first_seen_q <= 1'b1;
        first_q      <= cycle_cnt_q;
      end
      if (en && hit_start) begin
        armed_q <= 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        unique case (ch_state_q[i])
          ChIdle: begin
            if (armed_q && en) begin
              ch_state_q[i] <= ChWait;
              ch_cnt_q[i]   <= dly_load[i];
            end
          end
          ChWait: begin
            if (stop) begin
              ch_state_q[i] <= ChDone;
            end else if (en) begin
              if (ch_cnt_q[i] == DlyOne) begin
                ch_state_q[i] <= ChAssert;
                irq_q[i]      <= 1'b1;
              end
              ch_cnt_q[i] <= ch_cnt_q[i] - DlyOne;
            end
          end
          // Only the handler ack releases an asserted request.
          ChAssert: begin
            if (ack_hit[i]) begin
              irq_q[i] <= 1'b0;
              if (stop) begin
                ch_state_q[i] <= ChDone;
              end else begin
                ch_state_q[i] <= ChWait;
                ch_cnt_q[i]   <= dly_load[i];
              end
            end
          end
          ChDone: begin
          end
        endcase
      end
    end
  end

  assign ext_irq            = irq_q[0];
  assign sft_irq            = irq_q[1];
  assign tmr_irq            = irq_q[2];
  assign armed              = armed_q;
  assign done               = (ch_state_q[0] == ChDone) && (ch_state_q[1] == ChDone) &&
                              (ch_state_q[2] == ChDone);
  assign tohost_cnt         = tohost_cnt_q;
  assign cycle_cnt          = cycle_cnt_q;
  assign first_tohost_cycle = first_q;

endmodule

// File: tb/tb_irq_inject_sched.sv
// Directed bench for irq_inject_sched: arming, delay timing, ack, en gating, stop and reset.
module tb_irq_inject_sched;

  localparam logic [31:0] StartPc  = 32'h8000015C;
  localparam logic [31:0] ExtAckPc = 32'h800000A6;
  localparam logic [31:0] SftAckPc = 32'h800000BE;
  localparam logic [31:0] TmrAckPc = 32'h800000D6;
  localparam logic [31:0] TohostPc = 32'h80000086;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cmt_valid = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic        ext_irq, sft_irq, tmr_irq, armed, done;
  logic [31:0] tohost_cnt, cycle_cnt, first_tohost_cycle;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise [3];
  int rise_ref [3];

  irq_inject_sched dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .cmt_valid          (cmt_valid),
    .cmt_pc             (cmt_pc),
    .ext_irq            (ext_irq),
    .sft_irq            (sft_irq),
    .tmr_irq            (tmr_irq),
    .armed              (armed),
    .done               (done),
    .tohost_cnt         (tohost_cnt),
    .cycle_cnt          (cycle_cnt),
    .first_tohost_cycle (first_tohost_cycle)
  );

  always #5 clk = ~clk;

  // Bench-side count of edges since reset release.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] x;
    x = 16'hACE1;
    for (int k = 0; k < n; k++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    return x;
  endfunction

  function automatic int dly(input logic [15:0] x, input int ch);
    logic [9:0] w;
    case (ch)
      0:       w = x[9:0];
      1:       w = x[12:3];
      default: w = x[15:6];
    endcase
    return int'(w) + 1;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    cmt_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
  endtask

  // Arms at cycle 10 and records the first cycle each irq is seen high.
  task automatic run_arm(input bit gap);
    logic [2:0] irqs;
    bit pre_bad;
    int d, exp_r;
    pre_bad = 1'b0;
    for (int i = 0; i < 3; i++) rise[i] = -1;
    while (cyc < 1100 && (rise[0] < 0 || rise[1] < 0 || rise[2] < 0)) begin
      @(negedge clk);
      irqs = {tmr_irq, sft_irq, ext_irq};
      for (int i = 0; i < 3; i++) if (irqs[i] && rise[i] < 0) rise[i] = cyc;
      if (cyc <= 11 && irqs !== 3'b000) pre_bad = 1'b1;
      if (cyc == 6 || cyc == 11 || (gap && cyc == 9)) begin
        checks++;
        if (armed !== 1'(cyc == 11)) begin
          failures++;
          $display("FAIL armed_at_%0d got=%b exp=%b", cyc, armed, cyc == 11);
        end
      end
      cmt_valid = 1'b0;
      en = 1'b1;
      if (cyc == 5) begin cmt_valid = 1'b1; cmt_pc = SftAckPc; end
      if (cyc == 10 || (gap && cyc == 8)) begin cmt_valid = 1'b1; cmt_pc = StartPc; end
      if (gap && (cyc == 8 || (cyc >= 13 && cyc <= 62))) en = 1'b0;
    end
    checks++;
    if (pre_bad) begin
      failures++;
      $display("FAIL pre_arm_irq got=irq_before_arm exp=none");
    end
    for (int i = 0; i < 3; i++) begin
      d = dly(lfsr_at(11), i);
      exp_r = gap ? ((d <= 1) ? 13 : 62 + d) : 12 + d;
      checks++;
      if (rise[i] != exp_r) begin
        failures++;
        $display("FAIL rise_ch%0d gap=%0d got=%0d exp=%0d", i, gap, rise[i], exp_r);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if ({ext_irq, sft_irq, tmr_irq, armed, done} !== 5'b0 || tohost_cnt !== 32'd0 ||
        cycle_cnt !== 32'd0 || first_tohost_cycle !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%0d/%0d/%0d exp=0",
               {ext_irq, sft_irq, tmr_irq, armed, done}, tohost_cnt, cycle_cnt,
               first_tohost_cycle);
    end
    @(negedge clk);
    checks++;
    if (cycle_cnt !== 32'd1) begin
      failures++;
      $display("FAIL cycle_cnt_after_reset got=%0d exp=1", cycle_cnt);
    end
  endtask

  task automatic test_arm();
    run_arm(1'b0);
    for (int i = 0; i < 3; i++) rise_ref[i] = rise[i];
  endtask

  task automatic test_reset_mid_assert();
    int f;
    @(negedge clk);
    f = cyc;
    cmt_valid = 1'b1; cmt_pc = TohostPc;
    @(negedge clk);
    @(negedge clk);
    cmt_valid = 1'b0;
    checks++;
    if (tohost_cnt !== 32'd2 || first_tohost_cycle !== 32'(f)) begin
      failures++;
      $display("FAIL tohost_two got=%0d/%0d exp=2/%0d", tohost_cnt, first_tohost_cycle, f);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ext_irq, sft_irq, tmr_irq, armed, done} !== 5'b0 || tohost_cnt !== 32'd0 ||
        cycle_cnt !== 32'd0 || first_tohost_cycle !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_assert got=%b/%0d/%0d exp=0",
               {ext_irq, sft_irq, tmr_irq, armed, done}, tohost_cnt, cycle_cnt);
    end
    rst = 1'b0;
    run_arm(1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rise[i] != rise_ref[i]) begin
        failures++;
        $display("FAIL rerun_rise_ch%0d got=%0d exp=%0d", i, rise[i], rise_ref[i]);
      end
    end
  endtask

  task automatic test_ack();
    int a, exp_r, got;
    a = cyc;
    cmt_valid = 1'b1; cmt_pc = ExtAckPc;
    @(negedge clk);
    checks++;
    if (ext_irq !== 1'b0) begin
      failures++;
      $display("FAIL ext_ack_drop got=%b exp=0", ext_irq);
    end
    checks++;
    if ({sft_irq, tmr_irq} !== 2'b11) begin
      failures++;
      $display("FAIL others_held got=%b exp=11", {sft_irq, tmr_irq});
    end
    exp_r = a + 1 + dly(lfsr_at(a), 0);
    got = -1;
    // Second ack lands while ext is waiting and must be ignored.
    while (got < 0 && cyc < a + 1100) begin
      @(negedge clk);
      cmt_valid = 1'b0;
      if (ext_irq) got = cyc;
    end
    checks++;
    if (got != exp_r) begin
      failures++;
      $display("FAIL ext_rearm got=%0d exp=%0d", got, exp_r);
    end
  endtask

  task automatic test_en_gap();
    do_reset(2);
    run_arm(1'b1);
  endtask

  task automatic test_stop();
    int f, a, d, s;
    do_reset(2);
    run_arm(1'b0);
    repeat (5) begin
      @(negedge clk);
      en = 1'b0;
    end
    @(negedge clk);
    en = 1'b1;
    checks++;
    if ({ext_irq, sft_irq, tmr_irq} !== 3'b111) begin
      failures++;
      $display("FAIL held_en_low got=%b exp=111", {ext_irq, sft_irq, tmr_irq});
    end
    f = cyc + 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      cmt_valid = 1'b1; cmt_pc = TohostPc;
    end
    @(negedge clk);
    checks++;
    if (tohost_cnt !== 32'd32) begin
      failures++;
      $display("FAIL tohost_32 got=%0d exp=32", tohost_cnt);
    end
    a = cyc;
    cmt_pc = ExtAckPc;
    @(negedge clk);
    checks++;
    if (ext_irq !== 1'b0) begin
      failures++;
      $display("FAIL ext_ack_no_stop got=%b exp=0", ext_irq);
    end
    d = dly(lfsr_at(a), 0);
    cmt_pc = TohostPc;
    repeat (4) begin
      @(negedge clk);
      cmt_valid = 1'b0;
    end
    checks++;
    if (tohost_cnt !== 32'd33 || first_tohost_cycle !== 32'(f)) begin
      failures++;
      $display("FAIL tohost_33 got=%0d/%0d exp=33/%0d", tohost_cnt, first_tohost_cycle, f);
    end
    checks++;
    if ({ext_irq, sft_irq, tmr_irq} !== {1'(d == 1), 2'b11} || done !== 1'b0) begin
      failures++;
      $display("FAIL stop_hold got=%b done=%b exp=%b done=0", {ext_irq, sft_irq, tmr_irq},
               done, {1'(d == 1), 2'b11});
    end
    s = cyc;
    cmt_valid = 1'b1; cmt_pc = SftAckPc;
    @(negedge clk);
    checks++;
    if (sft_irq !== 1'b0 || tmr_irq !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL sft_ack_stop got=%b%b done=%b exp=01 done=0", sft_irq, tmr_irq, done);
    end
    cmt_pc = TmrAckPc;
    @(negedge clk);
    cmt_valid = 1'b0;
    checks++;
    if (tmr_irq !== 1'b0 || done !== 1'b1 || cyc != s + 2) begin
      failures++;
      $display("FAIL done_after_tmr_ack got=%b done=%b exp=0 done=1", tmr_irq, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || {ext_irq, sft_irq, tmr_irq} !== 3'b000) begin
      failures++;
      $display("FAIL done_terminal got=%b irqs=%b exp=1 irqs=000", done,
               {ext_irq, sft_irq, tmr_irq});
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_reset_mid_assert();
    test_ack();
    test_en_gap();
    test_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
